pbus_wb_master: RTL and testbench
=================================

# pbus_wb_master

Wishbone initiator for the 12-bit/8-bit on-chip peripheral bus. It turns single CPU load/store requests into Wishbone classic cycles. It drives the config/SYSCALL/SPM window at 0xC00000–0xC00FFF from the core side. Each access terminates in one of two ways, set by the system controller's SYNC_MODE/ASYNC_WAITCYCLE outputs: on the responder's ACK (sync mode), or after a fixed number of wait cycles (async mode).

## Interface
- TIMEOUT_CYCLES, 255: sync-mode cycles without ACK before the access is aborted. Only used when PBUS_TIMEOUT_EN is defined. Range 1–255.

- clk  input  1  system core clock
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  access request; sampled only in IDLE
- cpu_we  input  1  1 = write, 0 = read
- cpu_adr  input  12  byte address inside the 4K window
- cpu_wdat  input  8  write data
- cpu_rdat  output  8  read data; valid while cpu_done=1
- cpu_done  output  1  one-cycle completion pulse
- cpu_err  output  1  timeout flag; qualified by cpu_done
- cpu_busy  output  1  high in ACCESS and RESP
- SYNC_MODE  input  1  1 = terminate on ACK, 0 = terminate on wait count
- ASYNC_WAITCYCLE  input  7  async wait count N
- WB_ADRo  output  12  address
- WB_DATo  output  8  write data
- WB_DATi  input  8  read data
- WB_WEo  output  1  write enable
- WB_CYCo  output  1  cycle
- WB_STBo  output  1  strobe; identical to WB_CYCo
- WB_ACKi  input  1  acknowledge

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On cpu_req=1, register cpu_adr, cpu_we and cpu_wdat onto the WB outputs.
  - Latch SYNC_MODE and ASYNC_WAITCYCLE into a mode register. Changes to these inputs during an access have no effect.
  - Clear the wait counter (8 bits) and go to ACCESS.
- ACCESS:
  - WB_CYCo = WB_STBo = 1; address, data and WE are held stable.
  - Sync mode: ACK sampled high → capture WB_DATi into cpu_rdat (reads only; writes leave cpu_rdat unchanged) → RESP.
  - Async mode: WB_ACKi is ignored. When counter == N, capture WB_DATi → RESP. Otherwise the counter increments.
- RESP:
  - cpu_done=1, CYC/STB=0 → IDLE.
  - cpu_req is ignored in ACCESS and RESP, so no queuing.
- Reset values:
  - All outputs 0, cpu_rdat = 8'h00, state IDLE, counter 0.
  - Reset asserted mid-access drops CYC/STB in the same instant. No cpu_done follows.

## Timing
- Reads are captured at the terminating clock edge of ACCESS.
- Cycle 0: IDLE with cpu_req=1.
- Cycle 1: first ACCESS cycle; CYC/STB high.
- Sync mode, ACK first sampled high in ACCESS cycle k (k ≥ 1): RESP in cycle k+1. Minimum request-to-done latency is 2 cycles.
- Async mode: ACCESS lasts exactly N+1 cycles, so cpu_done is in cycle N+2.
  - N=0 → 1 ACCESS cycle.
  - N=127 → 128 ACCESS cycles; the counter does not wrap.
- Back-to-back accesses:
  - The earliest next request is sampled in the cycle after RESP.
  - There is a minimum of one idle cycle with CYC=0 between Wishbone cycles.
- An ACK arriving in IDLE or RESP is ignored.

## Configuration
- PBUS_TIMEOUT_EN defined:
  - In sync mode, if the counter reaches TIMEOUT_CYCLES without ACK, the access moves to RESP with cpu_done=1, cpu_err=1 and cpu_rdat=8'h00.
  - The counter increments only in ACCESS. If ACK arrives in the same cycle as the timeout, ACK wins and cpu_err=0.
- PBUS_TIMEOUT_EN undefined:
  - Sync mode waits indefinitely.
  - cpu_err is tied to 0 and the timeout compare logic is absent.

## Structure
- Shared package pbus_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - the window base constants: STK 0x600, ITC 0x6F0, SYC 0x6F8, SCL 0x700, SPM 0x800;
  - the default TIMEOUT_CYCLES.
- A single file, with no sub-module. The wait/timeout counter is inline.

## Test plan
- Sync read: mode=1, read 0x6F0, responder ACKs in the 3rd ACCESS cycle with 8'hA5 → cpu_done in cycle 4, cpu_rdat=8'hA5, cpu_err=0, WB_WEo=0 throughout.
- Async write: mode=0, N=5, write 8'h3C to 0x800 → CYC/STB high for exactly 6 cycles, WB_DATo=8'h3C, WB_WEo=1, done in cycle 7, ACK ignored.
- Async N=0 read of 0x600 with WB_DATi=8'h11 → 1 ACCESS cycle, cpu_rdat=8'h11. Flipping SYNC_MODE/ASYNC_WAITCYCLE mid-access does not change the length.
- Timeout (PBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): sync read with no ACK → done with cpu_err=1, cpu_rdat=00, CYC deasserted. Repeat with ACK in the same cycle as the timeout → cpu_err=0.
- Reset and back-to-back:
  - rst low during ACCESS → all outputs 0 immediately, no done.
  - Two sequential requests → ≥1 cycle with CYC=0 between them.
  - cpu_req held high during busy → no extra access.

Source files
------------

// File: rtl/pbus_pkg.sv
// pbus_pkg: shared state encoding, window bases and timeout default for the peripheral bus initiator.
package pbus_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
  localparam logic [11:0] STK = 12'h600;
  localparam logic [11:0] ITC = 12'h6F0;
  localparam logic [11:0] SYC = 12'h6F8;
  localparam logic [11:0] SCL = 12'h700;
  localparam logic [11:0] SPM = 12'h800;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
endpackage

// File: rtl/pbus_wb_master.sv
// pbus_wb_master: turns single CPU load/store requests into Wishbone classic cycles, ACK- or wait-count-terminated.
// Define PBUS_TIMEOUT_EN to abort sync-mode accesses that see no ACK within TIMEOUT_CYCLES.
module pbus_wb_master
  import pbus_pkg::*;
`ifdef PBUS_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_adr,
  input  logic [7:0]  cpu_wdat,
  output logic [7:0]  cpu_rdat,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_busy,
  input  logic        SYNC_MODE,
  input  logic [6:0]  ASYNC_WAITCYCLE,
  output logic [11:0] WB_ADRo,
  output logic [7:0]  WB_DATo,
  input  logic [7:0]  WB_DATi,
  output logic        WB_WEo,
  output logic        WB_CYCo,
  output logic        WB_STBo,
  input  logic        WB_ACKi
);
  state_t      state;
  logic        sync_q;
  logic [6:0]  n_q;
  logic [7:0]  cnt;
  logic        ack_term, cnt_term, tmo;
  assign ack_term = sync_q && WB_ACKi;
  assign cnt_term = !sync_q && (cnt == {1'b0, n_q});
`ifdef PBUS_TIMEOUT_EN
  // ACK in the timeout cycle takes priority, so the timeout only fires without ACK
  assign tmo = sync_q && !WB_ACKi && (cnt == 8'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif
  assign WB_STBo = WB_CYCo;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      sync_q   <= 1'b0;
      n_q      <= '0;
      cnt      <= '0;
      cpu_rdat <= '0;
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      cpu_busy <= 1'b0;
      WB_ADRo  <= '0;
      WB_DATo  <= '0;
      WB_WEo   <= 1'b0;
      WB_CYCo  <= 1'b0;
    end else
      case (state)
        IDLE: if (cpu_req) begin
          state    <= ACCESS;
          WB_ADRo  <= cpu_adr;
          WB_DATo  <= cpu_wdat;
          WB_WEo   <= cpu_we;
          WB_CYCo  <= 1'b1;
          cpu_busy <= 1'b1;
          sync_q   <= SYNC_MODE;
          n_q      <= ASYNC_WAITCYCLE;
          cnt      <= '0;
        end
        ACCESS: if (ack_term || cnt_term || tmo) begin
          state    <= RESP;
          WB_CYCo  <= 1'b0;
          cpu_done <= 1'b1;
          cpu_err  <= tmo;
          cpu_rdat <= tmo ? 8'h00 : (WB_WEo ? cpu_rdat : WB_DATi);
        end else
          cnt <= cnt + 8'd1;
        RESP: begin
          state    <= IDLE;
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_pbus_wb_master.sv
// tb_pbus_wb_master: directed and randomized accesses checked against a cycle-count model of the initiator.
module tb_pbus_wb_master;
  import pbus_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_adr = '0;
  logic [7:0]  cpu_wdat = '0, cpu_rdat;
  logic        cpu_done, cpu_err, cpu_busy;
  logic        SYNC_MODE = 1'b0;
  logic [6:0]  ASYNC_WAITCYCLE = '0;
  logic [11:0] WB_ADRo;
  logic [7:0]  WB_DATo, WB_DATi = '0;
  logic        WB_WEo, WB_CYCo, WB_STBo, WB_ACKi = 1'b0;
  int          checks = 0, failures = 0;
  logic [7:0]  exp_rdat = 8'h00;
  always #5 clk = ~clk;
`ifdef PBUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TO = 4;
  pbus_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .SYNC_MODE(SYNC_MODE), .ASYNC_WAITCYCLE(ASYNC_WAITCYCLE),
    .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi), .WB_WEo(WB_WEo),
    .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi));
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TO = 255;
  pbus_wb_master dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .SYNC_MODE(SYNC_MODE), .ASYNC_WAITCYCLE(ASYNC_WAITCYCLE),
    .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi), .WB_WEo(WB_WEo),
    .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of ACCESS cycles and error outcome; ack_k is the first ACCESS cycle with ACK high.
  function automatic void model(input logic sm, input logic [6:0] n, input int ack_k,
                                output int len, output logic err);
    len = sm ? ack_k : int'(n) + 1;
    err = 1'b0;
    if (TMO_EN && sm && ack_k > TO + 1) begin
      len = TO + 1;
      err = 1'b1;
    end
  endfunction

  // Called at a negedge (cycle 0); returns at the negedge of the idle cycle after RESP.
  task automatic access(input logic we, input logic [11:0] adr, input logic [7:0] wd,
                        input logic sm, input logic [6:0] n, input int ack_k, input logic [7:0] rd);
    int   len;
    logic err;
    model(sm, n, ack_k, len, err);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdat = wd;
    SYNC_MODE = sm; ASYNC_WAITCYCLE = n; WB_ACKi = 1'b0; WB_DATi = 8'($urandom);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk("access", 64'({WB_CYCo, WB_STBo, WB_WEo, WB_ADRo, WB_DATo, cpu_done, cpu_busy}),
          64'({2'b11, we, adr, wd, 2'b01}));
      cpu_we = 1'($urandom); cpu_adr = 12'($urandom); cpu_wdat = 8'($urandom);
      SYNC_MODE = 1'($urandom); ASYNC_WAITCYCLE = 7'($urandom);
      WB_ACKi = sm ? (c >= ack_k) : 1'($urandom);
      WB_DATi = (sm ? (c >= ack_k) : (c == len)) ? rd : ~rd;
    end
    @(negedge clk);
    if (err) exp_rdat = 8'h00;
    else if (!we) exp_rdat = rd;
    chk("resp", 64'({WB_CYCo, WB_STBo, cpu_done, cpu_busy, cpu_err, cpu_rdat}),
        64'({4'b0011, err, exp_rdat}));
    cpu_req = 1'b0;
    WB_ACKi = 1'($urandom);
    @(negedge clk);
    chk("idle_gap", 64'({WB_CYCo, WB_STBo, cpu_done, cpu_busy, cpu_err}), 64'(5'b0));
    WB_ACKi = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_state", 64'({WB_CYCo, WB_STBo, WB_WEo, WB_ADRo, WB_DATo, cpu_done, cpu_err, cpu_busy, cpu_rdat}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, ITC, 8'h00, 1'b1, 7'd0, 3, 8'hA5);
    access(1'b1, SPM, 8'h3C, 1'b0, 7'd5, 0, 8'h77);
    access(1'b0, STK, 8'h00, 1'b0, 7'd0, 0, 8'h11);
    access(1'b0, SCL, 8'h00, 1'b1, 7'd9, 1, 8'h4E);
    access(1'b1, SYC, 8'hC3, 1'b1, 7'd0, 2, 8'h99);
    access(1'b0, SPM, 8'h00, 1'b0, 7'd127, 0, 8'hD2);
`ifdef PBUS_TIMEOUT_EN
    access(1'b0, SYC, 8'h00, 1'b1, 7'd0, 1000, 8'h5A);
    access(1'b0, SYC, 8'h00, 1'b1, 7'd0, TO + 1, 8'h6B);
`endif
    for (int i = 0; i < 40; i++) begin
      logic sm;
      int   k;
      sm = 1'($urandom);
      k  = TMO_EN ? (($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(1, 7)))
                  : int'($urandom_range(1, 8));
      access(1'($urandom), 12'($urandom), 8'($urandom), sm,
             ($urandom_range(0, 7) == 0) ? 7'd127 : 7'($urandom_range(0, 10)), k, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    access(1'b0, STK, 8'h00, 1'b1, 7'd0, 1, 8'hF0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = SCL; cpu_wdat = 8'h81;
    SYNC_MODE = 1'b0; ASYNC_WAITCYCLE = 7'd20;
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", 64'({WB_CYCo, cpu_busy}), 64'(2'b11));
    cpu_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_async", 64'({WB_CYCo, WB_STBo, WB_WEo, WB_ADRo, WB_DATo, cpu_done, cpu_err, cpu_busy, cpu_rdat}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", 64'({WB_CYCo, cpu_done, cpu_busy}), 64'(0));
    end
    rst = 1'b1;
    exp_rdat = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst", 64'({WB_CYCo, cpu_done, cpu_busy, cpu_rdat}), 64'(0));
    end
    access(1'b0, ITC, 8'h00, 1'b0, 7'd2, 0, 8'h3D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
